// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline hazard controller bus.
// Carries the pipeline-side status (memory request/response, ID source
// registers, EX destination/load/redirect) into the controller. It carries the
// register load/flush strobes, the gated memory strobes and the perf counters
// back out.
//   master : pipeline side (drives status, receives controls)
//   slave  : controller side
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             imem_read;
  logic             imem_resp;
  logic             dmem_req;
  logic             dmem_resp;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [4:0]       ex_rd;
  logic             ex_mem_read;
  logic             ex_br_taken;

  logic             pc_load;
  logic             if_id_load;
  logic             id_ex_load;
  logic             ex_mem_load;
  logic             mem_wb_load;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             imem_read_en;
  logic             dmem_req_en;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] bubble_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output imem_read, imem_resp, dmem_req, dmem_resp,
           id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           ex_rd, ex_mem_read, ex_br_taken,
    input  pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
           if_id_flush, id_ex_flush, imem_read_en, dmem_req_en,
           stall_cnt, bubble_cnt, flush_cnt
  );

  modport slave (
    input  imem_read, imem_resp, dmem_req, dmem_resp,
           id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           ex_rd, ex_mem_read, ex_br_taken,
    output pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
           if_id_flush, id_ex_flush, imem_read_en, dmem_req_en,
           stall_cnt, bubble_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central sequencer for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
// It handles the following hazards, listed from highest priority to lowest:
//   1. Memory stall: the whole pipe freezes while an imem/dmem access is outstanding.
//   2. EX redirect: IF/ID and ID/EX are squashed.
//   3. Load-use: one bubble goes into ID/EX while PC and IF/ID hold.
// Memory strobes are gated so that an access that already completed during
// a stall is not re-issued while the other memory is still outstanding.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   bus       pipeline_hazard_ctrl_if.slave (status in; loads, flushes,
//             gated strobes and saturating perf counters out)
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  pipeline_hazard_ctrl_if.slave   bus
);

  typedef enum logic {RUN, WAIT} state_t;

  state_t           state_q, state_d;
  logic             imem_done_q, dmem_done_q;
  logic             pend_i, pend_d, mstall, lu;
  logic             case_br, case_lu;
  logic [CNT_W-1:0] stall_q, bubble_q, flush_q;

  // A response arriving this cycle satisfies its request now, which gives
  // a release with no added latency.
  assign pend_i = bus.imem_read & ~imem_done_q & ~bus.imem_resp;
  assign pend_d = bus.dmem_req  & ~dmem_done_q & ~bus.dmem_resp;
  assign mstall = pend_i | pend_d;

  assign lu = bus.ex_mem_read & (bus.ex_rd != 5'd0) &
              ((bus.id_uses_rs1 & (bus.id_rs1 == bus.ex_rd)) |
               (bus.id_uses_rs2 & (bus.id_rs2 == bus.ex_rd)));

  assign case_br = ~rst & ~mstall & bus.ex_br_taken;
  assign case_lu = ~rst & ~mstall & ~bus.ex_br_taken & lu;

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    bus.pc_load     = 1'b0;
    bus.if_id_load  = 1'b0;
    bus.id_ex_load  = 1'b0;
    bus.ex_mem_load = 1'b0;
    bus.mem_wb_load = 1'b0;
    bus.if_id_flush = 1'b0;
    bus.id_ex_flush = 1'b0;

    case (state_q)
      RUN:     if (mstall)  state_d = WAIT;
      WAIT:    if (!mstall) state_d = RUN;
      default: state_d = RUN;
    endcase

    if (!rst && !mstall) begin
      bus.pc_load     = 1'b1;
      bus.if_id_load  = 1'b1;
      bus.id_ex_load  = 1'b1;
      bus.ex_mem_load = 1'b1;
      bus.mem_wb_load = 1'b1;
      if (bus.ex_br_taken) begin
        bus.if_id_flush = 1'b1;
        bus.id_ex_flush = 1'b1;
      end else if (lu) begin
        // Hold the dependent instruction in ID and send a bubble to EX.
        bus.pc_load     = 1'b0;
        bus.if_id_load  = 1'b0;
        bus.id_ex_flush = 1'b1;
      end
    end
  end

  // The done flags remember which side already completed in the current stall.
  always_ff @(posedge clk) begin
    if (rst || !mstall) begin
      imem_done_q <= 1'b0;
      dmem_done_q <= 1'b0;
    end else begin
      if (bus.imem_resp) imem_done_q <= 1'b1;
      if (bus.dmem_resp) dmem_done_q <= 1'b1;
    end
  end

  assign bus.imem_read_en = ~rst & bus.imem_read & ~imem_done_q;
  assign bus.dmem_req_en  = ~rst & bus.dmem_req  & ~dmem_done_q;

  // The counters saturate at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
      flush_q  <= '0;
    end else begin
      if (mstall  && !(&stall_q))  stall_q  <= stall_q  + 1'b1;
      if (case_lu && !(&bubble_q)) bubble_q <= bubble_q + 1'b1;
      if (case_br && !(&flush_q))  flush_q  <= flush_q  + 1'b1;
    end
  end

  assign bus.stall_cnt  = stall_q;
  assign bus.bubble_cnt = bubble_q;
  assign bus.flush_cnt  = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized + directed scoreboard bench for pipeline_hazard_ctrl.
// The driver applies one input vector per cycle and pushes the expected
// response from a reference model. A monitor on the falling edge pops the
// expected response and compares it. Two DUTs share the same stimulus: one
// with 32-bit counters and one with 4-bit counters, for saturation.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(32)) ifc();
  pipeline_hazard_ctrl_if #(.CNT_W(4))  ifs();

  assign ifs.imem_read   = ifc.imem_read;
  assign ifs.imem_resp   = ifc.imem_resp;
  assign ifs.dmem_req    = ifc.dmem_req;
  assign ifs.dmem_resp   = ifc.dmem_resp;
  assign ifs.id_rs1      = ifc.id_rs1;
  assign ifs.id_rs2      = ifc.id_rs2;
  assign ifs.id_uses_rs1 = ifc.id_uses_rs1;
  assign ifs.id_uses_rs2 = ifc.id_uses_rs2;
  assign ifs.ex_rd       = ifc.ex_rd;
  assign ifs.ex_mem_read = ifc.ex_mem_read;
  assign ifs.ex_br_taken = ifc.ex_br_taken;

  pipeline_hazard_ctrl #(.CNT_W(32)) dut   (.clk(clk), .rst(rst), .bus(ifc));
  pipeline_hazard_ctrl #(.CNT_W(4))  dut_s (.clk(clk), .rst(rst), .bus(ifs));

  typedef struct packed {
    logic       rst, ir, irs, dr, drs;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       mr, br;
  } stim_t;

  // ctl = {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush, imem_en, dmem_en}
  typedef struct {
    logic [8:0] ctl;
    int         st, bu, fl;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state. A request is "served" once its response has been
  // seen during the current stall episode. Event totals are plain integers,
  // and saturation is applied only when they are compared.
  bit m_served_i, m_served_d;
  int n_st, n_bu, n_fl;

  function automatic int sat4(int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic apply(input stim_t s);
    exp_t e;
    bit   wait_i, wait_d, frozen, hazard;
    @(posedge clk);
    #1;
    rst             = s.rst;
    ifc.imem_read   = s.ir;
    ifc.imem_resp   = s.irs;
    ifc.dmem_req    = s.dr;
    ifc.dmem_resp   = s.drs;
    ifc.id_rs1      = s.rs1;
    ifc.id_rs2      = s.rs2;
    ifc.id_uses_rs1 = s.u1;
    ifc.id_uses_rs2 = s.u2;
    ifc.ex_rd       = s.rd;
    ifc.ex_mem_read = s.mr;
    ifc.ex_br_taken = s.br;

    e.st = n_st; e.bu = n_bu; e.fl = n_fl;
    if (s.rst) begin
      e.ctl = 9'b0;
      m_served_i = 0; m_served_d = 0;
      n_st = 0; n_bu = 0; n_fl = 0;
    end else begin
      wait_i = s.ir && !m_served_i && !s.irs;
      wait_d = s.dr && !m_served_d && !s.drs;
      frozen = wait_i || wait_d;
      hazard = s.mr && s.rd != 0 &&
               ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
      if (frozen)        e.ctl[8:2] = 7'b00000_00;
      else if (s.br)     e.ctl[8:2] = 7'b11111_11;
      else if (hazard)   e.ctl[8:2] = 7'b00111_01;
      else               e.ctl[8:2] = 7'b11111_00;
      e.ctl[1] = s.ir && !m_served_i;
      e.ctl[0] = s.dr && !m_served_d;
      if (frozen) begin
        n_st++;
        if (s.irs) m_served_i = 1;
        if (s.drs) m_served_d = 1;
      end else begin
        m_served_i = 0; m_served_d = 0;
        if (s.br)        n_fl++;
        else if (hazard) n_bu++;
      end
    end
    exp_q.push_back(e);
  endtask

  // Monitor: one expected entry per driven cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    logic [8:0] got, got_s;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got   = {ifc.pc_load, ifc.if_id_load, ifc.id_ex_load, ifc.ex_mem_load, ifc.mem_wb_load,
               ifc.if_id_flush, ifc.id_ex_flush, ifc.imem_read_en, ifc.dmem_req_en};
      got_s = {ifs.pc_load, ifs.if_id_load, ifs.id_ex_load, ifs.ex_mem_load, ifs.mem_wb_load,
               ifs.if_id_flush, ifs.id_ex_flush, ifs.imem_read_en, ifs.dmem_req_en};
      chk("ctl",        32'(got),            32'(e.ctl));
      chk("ctl_small",  32'(got_s),          32'(e.ctl));
      chk("stall_cnt",  ifc.stall_cnt,       32'(e.st));
      chk("bubble_cnt", ifc.bubble_cnt,      32'(e.bu));
      chk("flush_cnt",  ifc.flush_cnt,       32'(e.fl));
      chk("stall_sat",  32'(ifs.stall_cnt),  32'(sat4(e.st)));
      chk("bubble_sat", 32'(ifs.bubble_cnt), 32'(sat4(e.bu)));
      chk("flush_sat",  32'(ifs.flush_cnt),  32'(sat4(e.fl)));
    end
  end

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  initial begin
    stim_t s, r;
    int wait_cyc;
    rst = 1'b1;
    ifc.imem_read = 0; ifc.imem_resp = 0; ifc.dmem_req = 0; ifc.dmem_resp = 0;
    ifc.id_rs1 = 0; ifc.id_rs2 = 0; ifc.id_uses_rs1 = 0; ifc.id_uses_rs2 = 0;
    ifc.ex_rd = 0; ifc.ex_mem_read = 0; ifc.ex_br_taken = 0;
    m_served_i = 0; m_served_d = 0; n_st = 0; n_bu = 0; n_fl = 0;
    repeat (2) @(posedge clk);

    r = idle(); r.rst = 1;

    // Reset state, then a single load-use bubble.
    apply(r);
    s = idle(); s.mr = 1; s.rd = 5; s.rs1 = 5; s.u1 = 1;
    apply(s);
    apply(idle());
    @(negedge clk);
    chk("t1_bubble_cnt", ifc.bubble_cnt, 32'd1);

    // A load into x0 is not a hazard.
    apply(r);
    s.rd = 0; s.rs1 = 0;
    apply(s);
    apply(idle());
    @(negedge clk);
    chk("t2_bubble_cnt", ifc.bubble_cnt, 32'd0);

    // Staggered responses: imem at t2, dmem at t5.
    apply(r);
    for (int t = 0; t <= 5; t++) begin
      s = idle(); s.ir = 1; s.dr = 1;
      s.irs = (t == 2); s.drs = (t == 5);
      apply(s);
    end
    apply(idle());
    @(negedge clk);
    chk("t3_stall_cnt", ifc.stall_cnt, 32'd5);

    // A redirect overrides a concurrent load-use hazard.
    apply(r);
    s = idle(); s.mr = 1; s.rd = 7; s.rs2 = 7; s.u2 = 1; s.br = 1;
    apply(s);
    apply(idle());
    @(negedge clk);
    chk("t4_flush_cnt", ifc.flush_cnt, 32'd1);
    chk("t4_bubble_cnt", ifc.bubble_cnt, 32'd0);

    // Reset in the middle of a stall that has imem already served.
    apply(r);
    for (int t = 0; t <= 4; t++) begin
      s = idle(); s.ir = 1; s.dr = 1;
      s.irs = (t == 2); s.rst = (t == 3);
      apply(s);
    end
    apply(idle());

    // A long dmem stall saturates the narrow counter.
    apply(r);
    for (int t = 0; t < 20; t++) begin
      s = idle(); s.dr = 1;
      apply(s);
    end
    apply(idle());
    @(negedge clk);
    chk("t6_stall_sat", 32'(ifs.stall_cnt), 32'd15);
    chk("t6_stall_wide", ifc.stall_cnt, 32'd20);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      s.rst = ($urandom_range(0, 59) == 0);
      s.ir  = ($urandom_range(0, 3) != 0);
      s.irs = ($urandom_range(0, 2) == 0);
      s.dr  = ($urandom_range(0, 2) == 0);
      s.drs = ($urandom_range(0, 2) == 0);
      s.rs1 = 5'($urandom_range(0, 3));
      s.rs2 = 5'($urandom_range(0, 3));
      s.u1  = 1'($urandom_range(0, 1));
      s.u2  = 1'($urandom_range(0, 1));
      s.rd  = 5'($urandom_range(0, 3));
      s.mr  = 1'($urandom_range(0, 1));
      s.br  = ($urandom_range(0, 7) == 0);
      apply(s);
    end
    apply(idle());

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
